// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and default sizes for the VRAM arbiter
package vram_pkg;

    localparam int VRAM_AW = 11;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_CPU_RD
    } tag_t;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, display priority over CPU
// Optional VRAM_BLANK_ONLY_EN: CPU grants only while vblank is high.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          pclk,
    input  logic          clr,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vblank,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    logic          served;
    logic          cpu_ok;
    logic          cpu_pending;
    logic          grant_cpu;
    logic [AW-1:0] addr_nxt;
    tag_t          tag_nxt;
    tag_t          tag0;
    tag_t          tag1;

`ifdef VRAM_BLANK_ONLY_EN
    assign cpu_ok = vblank;
`else
    logic vblank_unused;
    assign vblank_unused = vblank;
    assign cpu_ok = 1'b1;
`endif

    assign cpu_pending = cpu_req && !served && cpu_ok;

    // Writes carry no read tag; their ack comes straight from ram_we.
    always_comb begin
        grant_cpu = 1'b0;
        addr_nxt  = ram_addr;
        tag_nxt   = TAG_NONE;
        if (disp_req) begin
            addr_nxt = disp_addr;
            tag_nxt  = TAG_DISP;
        end else if (cpu_pending) begin
            grant_cpu = 1'b1;
            addr_nxt  = cpu_addr;
            tag_nxt   = cpu_we ? TAG_NONE : TAG_CPU_RD;
        end
    end

    always_ff @(posedge pclk) begin
        if (clr) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            tag0       <= TAG_NONE;
            tag1       <= TAG_NONE;
            served     <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
        end else begin
            ram_addr <= addr_nxt;
            ram_we   <= grant_cpu && cpu_we;
            if (grant_cpu && cpu_we) begin
                ram_wdata <= cpu_wdata;
            end
            tag0   <= tag_nxt;
            tag1   <= tag0;
            // Held until the requester drops its level, so one ack per request.
            served <= cpu_req && (served || grant_cpu);

            disp_valid <= (tag1 == TAG_DISP);
            if (tag1 == TAG_DISP) begin
                disp_data <= ram_rdata;
            end
            cpu_ack <= (tag1 == TAG_CPU_RD) || ram_we;
            if (tag1 == TAG_CPU_RD) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the video card's single-port synchronous character/attribute RAM between two requesters: the scanout fetch path (display) and the Z80 bus-side CPU port.
- Display has strict priority so scanout never misses a fetch. The CPU is served in free slots using a level-request / single-cycle-ack handshake.
- Sits between the 640x480 timing/pixel pipeline and the external VRAM, in the pclk (25 MHz) domain.

Parameters:
- AW, 11, VRAM address width (2K x DW).
- DW, 8, VRAM data width.

Ports:
- pclk  in  1  pixel clock, 25 MHz; all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- disp_req  in  1  display fetch request, one-cycle strobe.
- disp_addr  in  AW  display fetch address, valid with disp_req.
- disp_data  out  DW  fetched display data.
- disp_valid  out  1  one-cycle strobe; disp_data is valid.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data; stable while cpu_req is high.
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion strobe.
- vblank  in  1  vertical blanking flag from the timing generator; used only with the optional feature.
- ram_addr  out  AW  VRAM address, registered.
- ram_wdata  out  DW  VRAM write data, registered.
- ram_we  out  1  VRAM write enable, registered.
- ram_rdata  in  DW  VRAM read data, valid one cycle after the address edge.

Behaviour:
- Reset values: disp_data=0, disp_valid=0, cpu_rdata=0, cpu_ack=0, ram_addr=0, ram_wdata=0, ram_we=0. All pipeline tags and the served flag are cleared.
- One VRAM slot per pclk cycle. The grant is decided combinationally from the inputs at edge E0; ram_addr, ram_we and ram_wdata are registered at E0.
- Pipeline: the RAM latches at E1 and ram_rdata is valid after E1. The arbiter captures it at E2. Two-stage tag shift register, tag in {NONE, DISP, CPU_RD}.
- Display read latency: disp_req at E0 gives disp_valid=1 and disp_data after E2. Fixed 2 cycles, never stalled.
- Grant priority:
  - disp_req > pending CPU > idle.
  - Idle slot: ram_we=0, ram_addr holds its previous value, tag NONE.
- CPU pending means cpu_req=1 and served=0.
- CPU write granted at E0: ram_we=1 for exactly one cycle, served set at E0, cpu_ack pulses after E1.
- CPU read granted at E0: served set at E0, cpu_ack pulses with cpu_rdata after E2.
- served clears on the first edge with cpu_req=0. A request that stays high after its ack is never serviced twice.
- Ack count: exactly one cpu_ack per cpu_req high period, whatever its length.
- Simultaneous disp_req and pending CPU: the display wins and the CPU waits. The CPU is granted in the first cycle with disp_req=0.
- Back-to-back disp_req every cycle: the CPU starves. The display client guarantees at least one gap per 8 pclk.
- Same-address hazard: slot order is the access order. A write in slot N is visible to a read in slot N+1. No forwarding.
- cpu_req dropped before the grant: the request is cancelled and no ack is produced. Dropped after the grant: the access completes, the ack is still produced, and served clears.
- Reset mid-operation: in-flight tags are discarded and no disp_valid/cpu_ack is produced for them. An active ram_we deasserts at the reset edge.

Optional Feature:
- Macro: VRAM_BLANK_ONLY_EN.
- Defined: CPU grants occur only while vblank=1. Otherwise the CPU waits, holding served=0. A grant already issued completes normally even if vblank falls.
- Undefined: vblank is ignored and the CPU uses any free slot.

Decomposition:
- Package vram_pkg: tag enum (TAG_NONE, TAG_DISP, TAG_CPU_RD), default AW/DW constants.
- No sub-module is needed. The tag pipeline is two registers inside vram_arbiter.
- The grant logic stays in one always block.

Test Plan:
- Reset: after clr=1 for 2 cycles, every output is 0 and no disp_valid/cpu_ack appears for a request issued during reset.
- Display read: disp_req at addr 0x123 (RAM holds 0x41) -> disp_valid after 2 edges, disp_data=0x41. Back-to-back requests each return 2 cycles later, in order.
- CPU write then read: write 0x5A to 0x010 -> ram_we high for 1 cycle, ack after 1 edge. Then read 0x010 -> cpu_rdata=0x5A with ack 2 edges after grant.
- Conflict: disp_req and a CPU write in the same cycle -> display slot first, CPU write granted the next cycle, cpu_ack 1 cycle later. disp_data is unaffected.
- Held request: cpu_req held high for 10 cycles -> exactly one cpu_ack. After a drop and re-raise, a second ack.
- VRAM_BLANK_ONLY_EN: CPU write raised with vblank=0 -> no ram_we until vblank rises, then grant on the first free slot.
